// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared fetch state encodings and reset address
//
// Purpose: shared definitions for the instruction-fetch sequencer.
//   fetch_state_e       FETCH / ISSUE / HALTED sequencer states
//   RESET_PC_DEFAULT    first fetch address after reset
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/fetch_sequencer_return_stack.sv
// rtl/fetch_sequencer_return_stack.sv - small LIFO of return addresses
//
// Purpose: hardware return stack for call/return.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the stack)
//   push, push_data write push_data on top; ignored when full
//   pop             discard the top entry; ignored when empty
//   top             current top entry (don't-care when empty)
//   full, empty     occupancy flags
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      cnt;
  logic [PW-1:0]    top_idx;

  // When full, the low bits of cnt wrap to 0, so subtracting one still
  // lands on the last slot.
  assign top_idx = cnt[PW-1:0] - PW'(1);
  assign top     = mem[top_idx];
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - (PW+1)'(1);
    end
  end

  // Contents need no reset; only the occupancy count defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[cnt[PW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, instruction register and redirects
//
// Purpose: fetches instructions from a combinational ROM into ir and steps pc,
// applying halt / call / ret / redirect when the control unit retires ir.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_addr, mem_data  ROM address (copy of pc) and combinational ROM data
//   ir, ir_valid, pc    latched instruction, valid flag, its address
//   exec_done           retire ir this cycle; qualifies the controls below
//   redirect, call, ret, halt, redirect_addr   next-pc controls and target
//   halted, stack_err   halted state, sticky return-stack overflow/underflow
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                INSTR_W     = 16,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  input  logic               exec_done,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               call,
  input  logic               ret,
  input  logic               halt,
  output logic               halted,
  output logic               stack_err
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              ir_load;
  logic              ir_valid_nxt;
  logic              halted_nxt;
  logic              err_set;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;

  assign mem_addr = pc;
  assign pc_inc   = pc + ADDR_W'(1);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pc_inc),
    .pop       (pop),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_load      = 1'b0;
    ir_valid_nxt = ir_valid;
    halted_nxt   = halted;
    err_set      = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    case (state)
      FETCH: begin
        ir_load      = 1'b1;
        ir_valid_nxt = 1'b1;
        state_nxt    = ISSUE;
      end
      ISSUE: begin
        if (exec_done && ir_valid) begin
          ir_valid_nxt = 1'b0;
          if (halt) begin
            state_nxt  = HALTED;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = FETCH;
            // call outranks ret, and both outrank a plain redirect
            if (call) begin
              pc_nxt  = redirect_addr;
              push    = !stk_full;
              err_set = stk_full;
            end else if (ret) begin
              pc_nxt  = stk_empty ? pc_inc : stk_top;
              pop     = !stk_empty;
              err_set = stk_empty;
            end else if (redirect) begin
              pc_nxt = redirect_addr;
            end else begin
              pc_nxt = pc_inc;
            end
          end
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir_valid <= ir_valid_nxt;
      halted   <= halted_nxt;
      if (ir_load) begin
        ir <= mem_data;
      end
      if (err_set) begin
        stack_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] ir;
  logic        ir_valid;
  logic [7:0]  pc;
  logic        exec_done;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        call;
  logic        ret;
  logic        halt;
  logic        halted;
  logic        stack_err;

  logic [15:0] rom [256];
  int          vectors = 0;
  int          miscompares = 0;

  assign mem_data = rom[mem_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W      (8),
    .INSTR_W     (16),
    .STACK_DEPTH (4),
    .RESET_PC    (8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .pc            (pc),
    .exec_done     (exec_done),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .call          (call),
    .ret           (ret),
    .halt          (halt),
    .halted        (halted),
    .stack_err     (stack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ir_valid, then check the fetched instruction and its
  // address. lat >= 0 also checks how many negedges the fetch took.
  task automatic fetch_expect(input logic [7:0] p, input int lat);
    int n = 0;
    while (ir_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ir_valid", 32'(ir_valid), 32'd1);
    chk("pc", 32'(pc), 32'(p));
    chk("mem_addr", 32'(mem_addr), 32'(p));
    chk("ir", 32'(ir), 32'(16'h1000 + 16'(p)));
    if (lat >= 0) chk("latency", 32'(n), 32'(lat));
  endtask

  task automatic retire(input logic r, input logic c, input logic rt,
                        input logic h, input logic [7:0] a);
    redirect      = r;
    call          = c;
    ret           = rt;
    halt          = h;
    redirect_addr = a;
    exec_done     = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    redirect  = 1'b0;
    call      = 1'b0;
    ret       = 1'b0;
    halt      = 1'b0;
    redirect_addr = 8'h00;
  endtask

  initial begin
    logic [15:0] held;
    logic [7:0]  max_pc;

    for (int k = 0; k < 256; k++) rom[k] = 16'h1000 + 16'(k);
    rst_n = 1'b0;
    exec_done = 1'b0;
    redirect = 1'b0;
    call = 1'b0;
    ret = 1'b0;
    halt = 1'b0;
    redirect_addr = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_ir", 32'(ir), 32'h0000);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_stack_err", 32'(stack_err), 32'd0);
    rst_n = 1'b1;

    // straight-line fetch, one instruction per two cycles
    fetch_expect(8'h00, 1);
    retire(0, 0, 0, 0, 8'h00);
    chk("retire_clears_valid", 32'(ir_valid), 32'd0);
    fetch_expect(8'h01, 1);
    retire(0, 0, 0, 0, 8'h00);
    fetch_expect(8'h02, 1);
    for (int k = 3; k <= 6; k++) begin
      retire(0, 0, 0, 0, 8'h00);
      fetch_expect(8'(k), 1);
    end

    // redirect loop 3..6, 100 times
    max_pc = 8'h00;
    for (int i = 0; i < 100; i++) begin
      retire(1, 0, 0, 0, 8'h03);
      fetch_expect(8'h03, 1);
      for (int k = 4; k <= 6; k++) begin
        retire(0, 0, 0, 0, 8'h00);
        if (pc > max_pc) max_pc = pc;
        fetch_expect(8'(k), -1);
        if (pc > max_pc) max_pc = pc;
      end
    end
    chk("loop_max_pc", 32'(max_pc), 32'h06);
    retire(1, 0, 0, 0, 8'h10);
    fetch_expect(8'h10, 1);

    // call/return nesting
    retire(0, 1, 0, 0, 8'h40);
    fetch_expect(8'h40, 1);
    retire(0, 0, 0, 0, 8'h00);
    fetch_expect(8'h41, 1);
    retire(1, 1, 1, 0, 8'h50);          // call wins over ret and redirect
    fetch_expect(8'h50, 1);
    retire(1, 0, 1, 0, 8'h77);          // ret wins over redirect
    fetch_expect(8'h42, 1);
    retire(0, 0, 1, 0, 8'h00);
    fetch_expect(8'h11, 1);
    chk("nest_stack_err", 32'(stack_err), 32'd0);

    // overflow: five nested calls into a four-deep stack
    retire(0, 1, 0, 0, 8'h20);
    fetch_expect(8'h20, 1);
    retire(0, 1, 0, 0, 8'h30);
    fetch_expect(8'h30, 1);
    retire(0, 1, 0, 0, 8'h40);
    fetch_expect(8'h40, 1);
    retire(0, 1, 0, 0, 8'h50);
    fetch_expect(8'h50, 1);
    chk("full_no_err", 32'(stack_err), 32'd0);
    retire(0, 1, 0, 0, 8'h60);
    fetch_expect(8'h60, 1);
    chk("overflow_err", 32'(stack_err), 32'd1);
    retire(0, 0, 1, 0, 8'h00);
    fetch_expect(8'h41, 1);
    chk("err_sticky", 32'(stack_err), 32'd1);

    // underflow after reset
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_stack_err", 32'(stack_err), 32'd0);
    chk("rst2_pc", 32'(pc), 32'h00);
    rst_n = 1'b1;
    fetch_expect(8'h00, 1);
    retire(0, 0, 1, 0, 8'h00);
    chk("underflow_err", 32'(stack_err), 32'd1);
    fetch_expect(8'h01, 1);

    // wrap and stall at 8'hFF
    retire(1, 0, 0, 0, 8'hFF);
    fetch_expect(8'hFF, 1);
    held = ir;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ir", 32'(ir), 32'(held));
      chk("stall_valid", 32'(ir_valid), 32'd1);
    end
    retire(0, 0, 0, 0, 8'h00);
    fetch_expect(8'h00, 1);

    // pushed return address wraps too
    retire(1, 0, 0, 0, 8'hFF);
    fetch_expect(8'hFF, 1);
    retire(0, 1, 0, 0, 8'h80);
    fetch_expect(8'h80, 1);
    retire(0, 0, 1, 0, 8'h00);
    fetch_expect(8'h00, 1);

    // halt (other controls ignored), then asynchronous reset
    retire(1, 0, 0, 0, 8'h08);
    fetch_expect(8'h08, 1);
    retire(1, 1, 0, 1, 8'h33);
    for (int i = 0; i < 6; i++) begin
      exec_done = 1'b1;
      call = 1'b1;
      redirect_addr = 8'h44;
      @(negedge clk);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_ir_valid", 32'(ir_valid), 32'd0);
      chk("halt_pc", 32'(pc), 32'h08);
    end
    exec_done = 1'b0;
    call = 1'b0;
    redirect_addr = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 32'h00);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_stack_err", 32'(stack_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_expect(8'h00, 1);
    retire(0, 0, 0, 0, 8'h00);
    fetch_expect(8'h01, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
